// File: rtl/mips_pkg.sv
// Shared definitions for the 5-instruction MIPS core: opcodes, fetch FSM states and the fetch payload.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FUNC_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

  localparam logic [FUNC_W-1:0] FN_JR   = 6'h08;
  localparam logic [FUNC_W-1:0] FN_ADDU = 6'h21;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALTED
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register presenting one fetched instruction to decode over valid/ready.
module fetch_buffer
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid,
  input  logic         ready,
  output logic         accept_c
);

  assign accept_c = valid && ready;

  // Load and accept never coincide: loads happen only while the buffer is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (accept_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, decode valid/ready, JR redirect and halt.
// Define FETCH_DELAY_SLOT_EN to fetch the branch delay slot before a JR takes effect.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func_code,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        active
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         load;
  logic         accept;
  fetch_entry_t load_entry;
  fetch_entry_t entry;

`ifdef FETCH_DELAY_SLOT_EN
  logic [31:0] pending_target;
  logic        pending_valid;
`endif

  // pc only changes on accept, so the address is stable for the whole request.
  assign imem_addr  = pc;
  assign load       = imem_req && imem_ack;
  assign load_entry = '{pc: pc, word: imem_rdata};

  assign instr     = entry.word;
  assign instr_pc  = entry.pc;
  assign opcode    = entry.word[31:26];
  assign func_code = entry.word[5:0];

  fetch_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_entry (load_entry),
    .entry      (entry),
    .valid      (instr_valid),
    .ready      (instr_ready),
    .accept_c   (accept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      imem_req <= 1'b0;
      active   <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
      pending_target <= '0;
      pending_valid  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          active   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            state    <= HOLD;
            imem_req <= 1'b0;
          end
        end
        HOLD: begin
          if (accept) begin
            if (halt) begin
              state  <= HALTED;
              active <= 1'b0;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
              // A JR seen in the delay slot is dropped; the first target wins.
              if (pending_valid) begin
                pc            <= pending_target;
                pending_valid <= 1'b0;
              end else if (redirect) begin
                pending_target <= word_align(redirect_target);
                pending_valid  <= 1'b1;
                pc             <= pc_incr(pc);
              end else begin
                pc <= pc_incr(pc);
              end
`else
              if (redirect) begin
                pc <= word_align(redirect_target);
              end else begin
                pc <= pc_incr(pc);
              end
`endif
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; follows FETCH_DELAY_SLOT_EN if defined.
module tb_fetch_unit;
  import mips_pkg::*;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  localparam logic [31:0] A = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func_code;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halt;
  logic        active;

  int n_cmp;
  int n_bad;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .opcode          (opcode),
    .func_code       (func_code),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .active          (active)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: JRs at 0x10/0x14, halts near 0x1008, ADDIU tagged with address elsewhere.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'hBFC0_0010) return {OP_RTYPE, 5'd1, 15'd0, FN_JR};
    if (a == 32'hBFC0_0014) return {OP_RTYPE, 5'd2, 15'd0, FN_JR};
    if (a == 32'h0000_1008 || a == 32'h0000_100C) return {OP_HALT, 26'd0};
    return {OP_ADDIU, 5'd0, 5'd2, a[17:2]};
  endfunction

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic redir, input logic [31:0] tgt, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_ipc);
    vec_t v;
    v.rdy = 1'b1; v.redir = redir; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt, input logic hlt,
                     input logic ack, input logic bad);
    instr_ready     = rdy;
    redirect        = redir;
    redirect_target = tgt;
    halt            = hlt;
    imem_ack        = ack;
    imem_rdata      = bad ? 32'hDEAD_BEEF : instr_at(imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic e_act, input logic [31:0] e_ipc);
    logic [31:0] ei;
    ei = instr_at(e_ipc);
    chk(tag, "imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk(tag, "imem_addr", imem_addr, e_addr);
    chk(tag, "instr_valid", 32'(instr_valid), 32'(e_valid));
    chk(tag, "active", 32'(active), 32'(e_act));
    if (e_valid) begin
      chk(tag, "instr_pc", instr_pc, e_ipc);
      chk(tag, "instr", instr, ei);
      chk(tag, "opcode", 32'(opcode), 32'(ei[31:26]));
      chk(tag, "func_code", 32'(func_code), 32'(ei[5:0]));
    end
  endtask

  task automatic expect_reset(input string tag);
    chk(tag, "imem_req", 32'(imem_req), 32'd0);
    chk(tag, "imem_addr", imem_addr, A);
    chk(tag, "instr_valid", 32'(instr_valid), 32'd0);
    chk(tag, "active", 32'(active), 32'd0);
  endtask

  initial begin
    logic [31:0] x;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    instr_ready = 1'b0; redirect = 1'b0; redirect_target = '0; halt = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    vecs[0]  = mk(1'b0, 32'h0,         1'b1, A,                              1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 32'h0,         1'b0, 32'h0,                          1'b1, A);
    vecs[2]  = mk(1'b0, 32'h0,         1'b1, A + 32'h4,                      1'b0, 32'h0);
    vecs[3]  = mk(1'b0, 32'h0,         1'b0, 32'h0,                          1'b1, A + 32'h4);
    vecs[4]  = mk(1'b0, 32'h0,         1'b1, A + 32'h8,                      1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 32'h0,         1'b0, 32'h0,                          1'b1, A + 32'h8);
    vecs[6]  = mk(1'b0, 32'h0,         1'b1, A + 32'hC,                      1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 32'h0,         1'b0, 32'h0,                          1'b1, A + 32'hC);
    vecs[8]  = mk(1'b0, 32'h0,         1'b1, A + 32'h10,                     1'b0, 32'h0);
    vecs[9]  = mk(1'b0, 32'h0,         1'b0, 32'h0,                          1'b1, A + 32'h10);
    vecs[10] = mk(1'b1, 32'h0000_1002, 1'b1, DS ? A + 32'h14 : 32'h1000,     1'b0, 32'h0);
    vecs[11] = mk(1'b0, 32'h0,         1'b0, 32'h0,                          1'b1, DS ? A + 32'h14 : 32'h1000);
    vecs[12] = mk(DS,   32'h0000_2000, 1'b1, DS ? 32'h1000 : 32'h1004,       1'b0, 32'h0);
    vecs[13] = mk(1'b0, 32'h0,         1'b0, 32'h0,                          1'b1, DS ? 32'h1000 : 32'h1004);
    vecs[14] = mk(1'b0, 32'h0,         1'b1, DS ? 32'h1004 : 32'h1008,       1'b0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    expect_reset("reset");
    chk("reset", "instr", instr, 32'h0);
    chk("reset", "instr_pc", instr_pc, 32'h0);
    reset = 1'b0;

    // Zero-wait memory: ack whenever a request is outstanding.
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].rdy, vecs[i].redir, vecs[i].tgt, 1'b0, imem_req, 1'b0);
      expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, 1'b1, vecs[i].e_ipc);
    end

    // Three wait cycles, then a 4-cycle decode stall with stray ack/redirect/halt.
    x = DS ? 32'h1004 : 32'h1008;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      expect_out($sformatf("wait%0d", k), 1'b1, x, 1'b0, 1'b1, 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_out("ack_late", 1'b0, 32'h0, 1'b1, 1'b1, x);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 32'h3000, 1'b1, 1'b1, 1'b1);
      expect_out($sformatf("stall%0d", k), 1'b0, 32'h0, 1'b1, 1'b1, x);
      chk($sformatf("stall%0d", k), "imem_addr", imem_addr, x);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("post_stall", 1'b1, x + 32'h4, 1'b0, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_out("next_instr", 1'b0, 32'h0, 1'b1, 1'b1, x + 32'h4);

    // Halt wins over redirect and is sticky.
    cyc(1'b1, 1'b1, 32'h4000, 1'b1, 1'b0, 1'b0);
    expect_out("halt", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 22; k++) begin
      cyc(1'b1, k[0], 32'h5000, 1'b1, 1'b1, 1'b0);
      expect_out($sformatf("halted%0d", k), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    // PC wrap at the top of the address space; target low bits are dropped.
    reset = 1'b1;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_reset("reset2");
    reset = 1'b0;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("w_req", 1'b1, A, 1'b0, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_out("w_hold", 1'b0, 32'h0, 1'b1, 1'b1, A);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    expect_out("w_jr", 1'b1, DS ? A + 32'h4 : 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
`ifdef FETCH_DELAY_SLOT_EN
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_out("w_slot", 1'b0, 32'h0, 1'b1, 1'b1, A + 32'h4);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("w_tgt", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0);
`endif
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_out("w_top", 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("w_wrap", 1'b1, 32'h0, 1'b0, 1'b1, 32'h0);

    // Reset during REQ; the late ack lands in IDLE and must be dropped.
    reset = 1'b1;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_reset("reset3");
    reset = 1'b0;
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    expect_out("r_late", 1'b1, A, 1'b0, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_out("r_wait", 1'b1, A, 1'b0, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    expect_out("r_fetch", 1'b0, 32'h0, 1'b1, 1'b1, A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
